// File: rtl/video_timing_controller_pkg.sv
// Shared definitions for the raster timing generator.
//   video_coord_w : width of every position / coordinate bus
//   coord_t       : unsigned coordinate type of that width
package video_timing_controller_pkg;

   localparam int video_coord_w = 14;

   typedef logic [video_coord_w-1:0] coord_t;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus its window decodes.
// The decodes describe the value the counter will hold after the coming
// edge, so a register fed by them lines up with the counter itself.
//   clk          : pixel clock
//   rst          : asynchronous active-high reset (position -> 0)
//   i_en         : advance the counter this edge
//   i_clr        : synchronous clear, wins over i_en and wrap
//   o_pos        : current position (registered)
//   o_in_sync    : next position lies inside the sync interval
//   o_in_visible : next position lies inside the visible window
//   o_offset     : next position minus the visible window start
module video_axis_counter
   import video_timing_controller_pkg::*;
#(
   parameter int unsigned AXIS_LENGTH = 800,
   parameter int unsigned SYNC_LEN    = 96,
   parameter int unsigned VIS_START   = 144,
   parameter int unsigned VISIBLE     = 640
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   output logic [video_coord_w-1:0] o_pos,
   output logic                     o_in_sync,
   output logic                     o_in_visible,
   output logic [video_coord_w-1:0] o_offset
);

   localparam coord_t LAST = coord_t'(AXIS_LENGTH - 1);
   localparam coord_t START_C = coord_t'(VIS_START);
   // One extra bit: window edges may equal 16384 at the upper limit.
   localparam logic [video_coord_w:0] SYNC_END = (video_coord_w+1)'(SYNC_LEN);
   localparam logic [video_coord_w:0] VIS_BEG = (video_coord_w+1)'(VIS_START);
   localparam logic [video_coord_w:0] VIS_END = (video_coord_w+1)'(VIS_START + VISIBLE);

   coord_t                  r_pos;
   coord_t                  w_next;
   logic [video_coord_w:0]  w_next_ext;

   always_comb begin
      w_next = r_pos;
      if (i_clr)
         w_next = '0;
      else if (i_en)
         w_next = (r_pos == LAST) ? '0 : r_pos + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pos <= '0;
      else
         r_pos <= w_next;
   end

   assign w_next_ext   = {1'b0, w_next};
   assign o_pos        = r_pos;
   assign o_in_sync    = (w_next_ext < SYNC_END);
   assign o_in_visible = (w_next_ext >= VIS_BEG) && (w_next_ext < VIS_END);
   assign o_offset     = w_next - START_C;

endmodule

// File: rtl/video_timing_controller.sv
// Raster timing generator: free-running horizontal/vertical counters on the
// pixel clock, decoded into syncs, data enable, line start and visible
// pixel coordinates. Every output is a register that describes the counter
// values shown on timing_h_pos/timing_v_pos in the same cycle.
//   pixel_clock      : sole clock
//   reset            : asynchronous active-high reset
//   ext_sync         : synchronous, level-sensitive frame restart to (0,0)
//   timing_h_pos/v   : raw counters
//   pixel_x/pixel_y  : visible coordinates, 0 outside the window
//   video_hsync/vsync: syncs at parameter polarity
//   video_den        : inside the visible window
//   video_line_start : first den clock of each visible line
module video_timing_controller
   import video_timing_controller_pkg::*;
#(
   parameter int unsigned video_hlength   = 800,
   parameter int unsigned video_vlength   = 525,
   parameter int unsigned video_hsync_pol = 0,
   parameter int unsigned video_hsync_len = 96,
   parameter int unsigned video_hbp_len   = 48,
   parameter int unsigned video_h_visible = 640,
   parameter int unsigned video_vsync_pol = 0,
   parameter int unsigned video_vsync_len = 2,
   parameter int unsigned video_vbp_len   = 33,
   parameter int unsigned video_v_visible = 480
) (
   input  logic                     pixel_clock,
   input  logic                     reset,
   input  logic                     ext_sync,
   output logic [video_coord_w-1:0] timing_h_pos,
   output logic [video_coord_w-1:0] timing_v_pos,
   output logic [video_coord_w-1:0] pixel_x,
   output logic [video_coord_w-1:0] pixel_y,
   output logic                     video_hsync,
   output logic                     video_vsync,
   output logic                     video_den,
   output logic                     video_line_start
);

   localparam int unsigned HS = video_hsync_len + video_hbp_len;
   localparam int unsigned VS = video_vsync_len + video_vbp_len;
   localparam coord_t H_LAST = coord_t'(video_hlength - 1);
   localparam logic HSYNC_ACT = (video_hsync_pol != 0);
   localparam logic VSYNC_ACT = (video_vsync_pol != 0);

   coord_t w_h_pos;
   coord_t w_v_pos;
   coord_t w_h_off;
   coord_t w_v_off;
   logic   w_h_in_sync;
   logic   w_v_in_sync;
   logic   w_h_in_vis;
   logic   w_v_in_vis;
   logic   w_h_wrap;
   logic   w_den;

   coord_t r_pixel_x;
   coord_t r_pixel_y;
   logic   r_hsync;
   logic   r_vsync;
   logic   r_den;
   logic   r_line_start;

   assign w_h_wrap = (w_h_pos == H_LAST);

   video_axis_counter #(
      .AXIS_LENGTH (video_hlength),
      .SYNC_LEN    (video_hsync_len),
      .VIS_START   (HS),
      .VISIBLE     (video_h_visible)
   ) u_h_axis (
      .clk          (pixel_clock),
      .rst          (reset),
      .i_en         (1'b1),
      .i_clr        (ext_sync),
      .o_pos        (w_h_pos),
      .o_in_sync    (w_h_in_sync),
      .o_in_visible (w_h_in_vis),
      .o_offset     (w_h_off)
   );

   video_axis_counter #(
      .AXIS_LENGTH (video_vlength),
      .SYNC_LEN    (video_vsync_len),
      .VIS_START   (VS),
      .VISIBLE     (video_v_visible)
   ) u_v_axis (
      .clk          (pixel_clock),
      .rst          (reset),
      .i_en         (w_h_wrap),
      .i_clr        (ext_sync),
      .o_pos        (w_v_pos),
      .o_in_sync    (w_v_in_sync),
      .o_in_visible (w_v_in_vis),
      .o_offset     (w_v_off)
   );

   assign w_den = w_h_in_vis && w_v_in_vis;

   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         r_pixel_x    <= '0;
         r_pixel_y    <= '0;
         r_hsync      <= HSYNC_ACT;
         r_vsync      <= VSYNC_ACT;
         r_den        <= 1'b0;
         r_line_start <= 1'b0;
      end else begin
         r_pixel_x    <= w_den ? w_h_off : '0;
         r_pixel_y    <= w_den ? w_v_off : '0;
         r_hsync      <= w_h_in_sync ? HSYNC_ACT : ~HSYNC_ACT;
         r_vsync      <= w_v_in_sync ? VSYNC_ACT : ~VSYNC_ACT;
         r_den        <= w_den;
         // Offset 0 inside the horizontal window is exactly h_pos == HS.
         r_line_start <= w_v_in_vis && w_h_in_vis && (w_h_off == '0);
      end
   end

   assign timing_h_pos     = w_h_pos;
   assign timing_v_pos     = w_v_pos;
   assign pixel_x          = r_pixel_x;
   assign pixel_y          = r_pixel_y;
   assign video_hsync      = r_hsync;
   assign video_vsync      = r_vsync;
   assign video_den        = r_den;
   assign video_line_start = r_line_start;

endmodule

// File: tb/tb_video_timing_controller.sv
module tb_video_timing_controller;

   typedef struct {
      int hl, vl, hpol, hsl, hbp, hvis, vpol, vsl, vbp, vvis;
   } geom_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, ext_a, rst_b, ext_b;
   logic [13:0] a_h, a_v, a_px, a_py, b_h, b_v, b_px, b_py;
   logic a_hs, a_vs, a_den, a_ls, b_hs, b_vs, b_den, b_ls;

   int checks = 0;
   int failures = 0;
   int t_a, t_b;
   geom_t ga, gb;

   video_timing_controller dut_a (
      .pixel_clock(clk), .reset(rst_a), .ext_sync(ext_a),
      .timing_h_pos(a_h), .timing_v_pos(a_v), .pixel_x(a_px), .pixel_y(a_py),
      .video_hsync(a_hs), .video_vsync(a_vs), .video_den(a_den),
      .video_line_start(a_ls)
   );

   video_timing_controller #(
      .video_hlength(10), .video_vlength(8),
      .video_hsync_pol(1), .video_hsync_len(2), .video_hbp_len(1), .video_h_visible(5),
      .video_vsync_pol(1), .video_vsync_len(1), .video_vbp_len(1), .video_v_visible(4)
   ) dut_b (
      .pixel_clock(clk), .reset(rst_b), .ext_sync(ext_b),
      .timing_h_pos(b_h), .timing_v_pos(b_v), .pixel_x(b_px), .pixel_y(b_py),
      .video_hsync(b_hs), .video_vsync(b_vs), .video_den(b_den),
      .video_line_start(b_ls)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: position is elapsed clocks since the last restart, folded
   // into line and frame; every output follows from the window arithmetic.
   task automatic check_dut(input string tag, input geom_t g, input int t,
                            input logic [13:0] h, v, px, py,
                            input logic hs, vs, den, ls);
      int eh, ev, hs0, vs0;
      bit hv, vv, eden;
      eh   = t % g.hl;
      ev   = (t / g.hl) % g.vl;
      hs0  = g.hsl + g.hbp;
      vs0  = g.vsl + g.vbp;
      hv   = (eh >= hs0) && (eh < hs0 + g.hvis);
      vv   = (ev >= vs0) && (ev < vs0 + g.vvis);
      eden = hv && vv;
      chk({tag, ".h_pos"}, 32'(h), eh);
      chk({tag, ".v_pos"}, 32'(v), ev);
      chk({tag, ".pixel_x"}, 32'(px), eden ? eh - hs0 : 0);
      chk({tag, ".pixel_y"}, 32'(py), eden ? ev - vs0 : 0);
      chk({tag, ".hsync"}, 32'(hs), (eh < g.hsl) ? g.hpol : 1 - g.hpol);
      chk({tag, ".vsync"}, 32'(vs), (ev < g.vsl) ? g.vpol : 1 - g.vpol);
      chk({tag, ".den"}, 32'(den), 32'(eden));
      chk({tag, ".line_start"}, 32'(ls), 32'((eh == hs0) && vv));
   endtask

   task automatic check_both();
      check_dut("A", ga, t_a, a_h, a_v, a_px, a_py, a_hs, a_vs, a_den, a_ls);
      check_dut("B", gb, t_b, b_h, b_v, b_px, b_py, b_hs, b_vs, b_den, b_ls);
   endtask

   // One clock: advance the model with the inputs the edge saw, then sample.
   task automatic step();
      @(posedge clk);
      if (rst_a || ext_a) t_a = 0; else t_a++;
      if (rst_b || ext_b) t_b = 0; else t_b++;
      #1;
      check_both();
   endtask

   initial begin
      ga = '{800, 525, 0, 96, 48, 640, 0, 2, 33, 480};
      gb = '{10, 8, 1, 2, 1, 5, 1, 1, 1, 4};
      rst_a = 1'b1; rst_b = 1'b1; ext_a = 1'b0; ext_b = 1'b0;
      t_a = 0; t_b = 0;

      #3;
      check_both();
      repeat (3) step();
      chk("rst_hsync_low", 32'(a_hs), 0);
      chk("rst_vsync_low", 32'(a_vs), 0);
      rst_a = 1'b0; rst_b = 1'b0;

      step();
      chk("first_h", 32'(a_h), 1);
      chk("first_v", 32'(a_v), 0);

      // Free run A through the first visible line; B gets random restarts.
      for (int n = 0; n < 29000; n++) begin
         step();
         if (t_a == 96) chk("hsync_release", 32'(a_hs), 1);
         if (t_a == 1599) chk("vsync_last_low", 32'(a_vs), 0);
         if (t_a == 1600) chk("vsync_release", 32'(a_vs), 1);
         if (t_a == 35*800 + 144) begin
            chk("den_rise", 32'(a_den), 1);
            chk("den_rise_px", 32'(a_px), 0);
            chk("den_rise_py", 32'(a_py), 0);
            chk("den_rise_ls", 32'(a_ls), 1);
         end
         if (t_a == 35*800 + 783) chk("last_px", 32'(a_px), 639);
         if (t_a == 35*800 + 784) chk("den_fall", 32'(a_den), 0);
         if (t_b % 10 == 3) chk("b_den_start", 32'(b_den), 32'(t_b / 10 % 8 >= 2 && t_b / 10 % 8 < 6));
         ext_b = ($urandom_range(0, 149) == 0);
      end
      ext_b = 1'b0;

      // Level-held restart on A at an arbitrary position.
      repeat ($urandom_range(1, 700)) step();
      ext_a = 1'b1;
      repeat (3) begin
         step();
         chk("ext_h", 32'(a_h), 0);
         chk("ext_v", 32'(a_v), 0);
         chk("ext_hsync", 32'(a_hs), 0);
         chk("ext_vsync", 32'(a_vs), 0);
      end
      ext_a = 1'b0;
      repeat (200) step();

      // Mid-line asynchronous reset, checked before any further edge.
      #2;
      rst_a = 1'b1; rst_b = 1'b1;
      #1;
      t_a = 0; t_b = 0;
      check_both();
      chk("async_rst_h", 32'(a_h), 0);
      repeat (2) step();
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (300) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
